// File: rtl/y86_alu64.sv
// 64-bit Y86 execute-stage ALU: add/sub/and/xor with registered result and OF/ZF/SF flags.
// One-cycle latency, a new operation every cycle, synchronous active-high reset.
module y86_alu64 #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       control,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic             OF,
    output logic             ZF,
    output logic             SF
);

    localparam int unsigned MSB = WIDTH - 1;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_XOR = 2'b11
    } op_e;

    op_e              op;
    logic             op_is_sub;
    logic [WIDTH-1:0] b_opnd;
    logic [WIDTH-1:0] sum;
    logic             sum_ovf;

    logic [WIDTH-1:0] out_d, out_q;
    logic             of_d, of_q;
    logic             zf_d, zf_q;
    logic             sf_d, sf_q;

    assign op = op_e'(control);

    // Shared adder: subtraction is a + ~b + 1, so one overflow rule covers both ops.
    always_comb begin
        op_is_sub = (op == OP_SUB);
        b_opnd    = op_is_sub ? ~b : b;
        sum       = a + b_opnd + WIDTH'(op_is_sub);
        sum_ovf   = (a[MSB] == b_opnd[MSB]) && (sum[MSB] != a[MSB]);
    end

    // Result select and flag generation; reset dominates any operation.
    always_comb begin
        out_d = '0;
        of_d  = 1'b0;
        zf_d  = 1'b0;
        sf_d  = 1'b0;
        if (!reset) begin
            case (op)
                OP_ADD, OP_SUB: begin
                    out_d = sum;
                    of_d  = sum_ovf;
                end
                OP_AND:  out_d = a & b;
                OP_XOR:  out_d = a ^ b;
                default: out_d = '0;
            endcase
            zf_d = (out_d == '0);
            sf_d = out_d[MSB];
        end
    end

    always_ff @(posedge clk) begin
        out_q <= out_d;
        of_q  <= of_d;
        zf_q  <= zf_d;
        sf_q  <= sf_d;
    end

    assign out = out_q;
    assign OF  = of_q;
    assign ZF  = zf_q;
    assign SF  = sf_q;

endmodule

// File: tb/tb_y86_alu64.sv
// Directed and randomized scoreboard bench for y86_alu64.
module tb_y86_alu64;

    typedef struct {
        logic [63:0] out;
        logic        of;
        logic        zf;
        logic        sf;
        string       tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  control;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] out;
    logic        OF;
    logic        ZF;
    logic        SF;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    y86_alu64 #(.WIDTH(64)) dut (
        .clk(clk), .reset(reset), .control(control), .a(a), .b(b),
        .out(out), .OF(OF), .ZF(ZF), .SF(SF)
    );

    always #5 clk = ~clk;

    // Reference model using 65-bit signed arithmetic for overflow detection.
    function automatic void model(input logic [1:0] c, input logic [63:0] ia, input logic [63:0] ib,
                                  output logic [63:0] ro, output logic rof);
        logic [64:0] wide;
        wide = '0;
        rof  = 1'b0;
        case (c)
            2'b00: begin wide = {ia[63], ia} + {ib[63], ib}; ro = wide[63:0]; rof = wide[64] != wide[63]; end
            2'b01: begin wide = {ia[63], ia} - {ib[63], ib}; ro = wide[63:0]; rof = wide[64] != wide[63]; end
            2'b10: ro = ia & ib;
            default: ro = ia ^ ib;
        endcase
    endfunction

    task automatic check_out();
        exp_t e;
        n_cmp++;
        assert (sb.size() != 0) else begin
            n_bad++;
            $error("FAIL scoreboard_empty: got size %0d exp >0", sb.size());
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            n_cmp++;
            assert (out === e.out) else begin
                n_bad++; $error("FAIL %s.out: got %h exp %h", e.tag, out, e.out);
            end
            n_cmp++;
            assert (OF === e.of) else begin
                n_bad++; $error("FAIL %s.OF: got %b exp %b", e.tag, OF, e.of);
            end
            n_cmp++;
            assert (ZF === e.zf) else begin
                n_bad++; $error("FAIL %s.ZF: got %b exp %b", e.tag, ZF, e.zf);
            end
            n_cmp++;
            assert (SF === e.sf) else begin
                n_bad++; $error("FAIL %s.SF: got %b exp %b", e.tag, SF, e.sf);
            end
        end
    endtask

    // Drive one operation, push its expectation, check after the capturing edge.
    task automatic step(input string tag, input logic rst, input logic [1:0] c,
                        input logic [63:0] ia, input logic [63:0] ib,
                        input logic [63:0] eo, input logic eof);
        exp_t e;
        @(negedge clk);
        reset   = rst;
        control = c;
        a       = ia;
        b       = ib;
        e.tag = tag;
        e.out = rst ? 64'd0 : eo;
        e.of  = rst ? 1'b0 : eof;
        e.zf  = rst ? 1'b0 : (eo == 64'd0);
        e.sf  = rst ? 1'b0 : eo[63];
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        logic [63:0] ra, rb, mo;
        logic [1:0]  rc;
        logic        mof;
        logic [63:0] and_a, and_b;

        reset = 1'b1; control = 2'b00; a = 64'd5; b = 64'd7;

        step("rst0", 1'b1, 2'b00, 64'd5, 64'd7, 64'd0, 1'b0);
        step("rst1", 1'b1, 2'b00, 64'd5, 64'd7, 64'd0, 1'b0);
        step("rel",  1'b0, 2'b00, 64'd5, 64'd7, 64'd12, 1'b0);

        step("add_pos",  1'b0, 2'b00, 64'd256, 64'd255, 64'd511, 1'b0);
        step("add_neg",  1'b0, 2'b00, -64'sd543, -64'sd464, -64'sd1007, 1'b0);
        step("add_ovfp", 1'b0, 2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 1'b1);
        step("add_ovfn", 1'b0, 2'b00, -64'sd9223372036854775000, -64'sd6000,
             64'd9223372036854770616, 1'b1);

        step("sub_neg",  1'b0, 2'b01, -64'sd7478, -64'sd46474, 64'd38996, 1'b0);
        step("sub_big",  1'b0, 2'b01, 64'd9223372036854775000, 64'd6000, 64'd9223372036854769000, 1'b0);
        step("sub_min",  1'b0, 2'b01, 64'd0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1);
        step("sub_zero", 1'b0, 2'b01, 64'd5, 64'd5, 64'd0, 1'b0);

        step("and_1",    1'b0, 2'b10, 64'd1092835, -64'sd1020, 64'd1092608, 1'b0);
        and_a = 64'd7890678653;
        and_b = 64'd4238598110567;
        step("and_2",    1'b0, 2'b10, and_a, and_b, and_a & and_b, 1'b0);

        step("xor_1",    1'b0, 2'b11, 64'd1092835, -64'sd1020, -64'sd1093401, 1'b0);
        step("xor_zero", 1'b0, 2'b11, 64'd12345, 64'd12345, 64'd0, 1'b0);

        step("b2b_add", 1'b0, 2'b00, 64'd100, 64'd23, 64'd123, 1'b0);
        step("b2b_sub", 1'b0, 2'b01, 64'd100, 64'd123, -64'sd23, 1'b0);
        step("b2b_and", 1'b0, 2'b10, 64'hF0F0, 64'hFF00, 64'hF000, 1'b0);
        step("b2b_rst", 1'b1, 2'b11, 64'hF0F0, 64'hFF00, 64'h0F00, 1'b0);
        step("b2b_xor", 1'b0, 2'b11, 64'hF0F0, 64'hFF00, 64'h0FF0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            ra = {$urandom(), $urandom()};
            rb = {$urandom(), $urandom()};
            rc = 2'($urandom_range(0, 3));
            if (i % 8 == 3) rb = 64'h8000_0000_0000_0000;
            if (i % 8 == 5) ra = 64'h7FFF_FFFF_FFFF_FFFF;
            model(rc, ra, rb, mo, mof);
            step($sformatf("rnd%0d", i), (i == 20), rc, ra, rb, mo, mof);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/y86_alu64.md
Name: y86_alu64

Overview:
- 64-bit integer ALU for the Y86 sequential processor's execute stage.
- Performs add, subtract, bitwise AND or bitwise XOR on two signed operands, selected by a 2-bit control code.
- Produces the result plus Y86 condition flags (OF, ZF, SF).
- Result and flags are registered: one clock, synchronous reset.

Parameters:
- WIDTH, 64, operand/result width in bits (all test values assume 64).

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- control  input  2  operation select: 00 add, 01 sub, 10 and, 11 xor
- a  input  WIDTH  signed operand A
- b  input  WIDTH  signed operand B
- out  output  WIDTH  signed registered result
- OF  output  1  registered signed-overflow flag
- ZF  output  1  registered zero flag (out == 0)
- SF  output  1  registered sign flag (out[WIDTH-1])

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
  - Sampled only on rising clk.
  - While reset=1 at an edge: out=0, OF=0, ZF=0, SF=0.
  - Reset dominates any operation presented in the same cycle.
  - Reset mid-stream discards the in-flight result.
- Latency:
  - Fully combinational compute from control/a/b; registered on each rising edge with reset=0.
  - Result of inputs present before edge N is visible after edge N (1-cycle latency).
  - No handshake; a new operation is accepted every cycle.
- Arithmetic (two's complement, WIDTH-bit wrap-around, carry-out discarded):
  - 00: out = a + b. OF=1 iff a and b have equal sign and out's sign differs.
  - 01: out = a - b (A minus B). OF=1 iff a and b have different signs and out's sign differs from a.
  - 10: out = a & b; OF=0.
  - 11: out = a ^ b; OF=0.
- Flags for all ops:
  - ZF = (out == 0).
  - SF = out[WIDTH-1].
  - Flags correspond to the same-cycle result as out.
- Boundary conditions:
  - Overflow wraps silently; OF is the only indication.
  - Subtract with b = most-negative value: computed as a + (~b) + 1 with overflow per the sub rule (e.g. 0 - MIN gives MIN, OF=1).
  - Implementation may use a shared adder with b inverted and carry-in=1 for sub.
- No X-propagation tolerance: all outputs driven from reset onward.

Test Plan:
- Reset: hold reset=1 for 2 cycles with control=00, a=5, b=7 -> out=0, OF=ZF=SF=0. Release reset -> next edge out=12.
- Add:
  - a=256, b=255 -> out=511, OF=0.
  - a=-543, b=-464 -> out=-1007, SF=1, OF=0.
  - a=0x7FFFFFFFFFFFFFFF, b=1 -> out=0x8000000000000000, OF=1, SF=1.
  - a=-9223372036854775000, b=-6000 -> out=9223372036854770616, OF=1, SF=0.
- Sub:
  - a=-7478, b=-46474 -> out=38996, OF=0.
  - a=9223372036854775000, b=6000 -> out=9223372036854769000, OF=0.
  - a=0, b=0x8000000000000000 -> out=0x8000000000000000, OF=1.
  - a=5, b=5 -> out=0, ZF=1.
- AND: a=1092835, b=-1020 -> out=1092608, OF=0. a=7890678653, b=4238598110567 -> out equals bitwise a&b, OF=0.
- XOR: a=1092835, b=-1020 -> out=-1093401, SF=1, OF=0. a=b=12345 -> out=0, ZF=1.
- Back-to-back ops: change control and operands every cycle (add, sub, and, xor) -> each result appears exactly one edge later. Assert reset mid-sequence -> outputs 0 at that edge, then normal results resume.
